// File: rtl/xbar_rr_sched.sv
// Round-robin priority pointer scheduler for a full-duplex crossbar.
// Pointers advance past the last served port on real handshakes, or after an idle timeout.
module xbar_rr_sched #(
    parameter int unsigned NumIn      = 4,
    parameter int unsigned NumOut     = 4,
    parameter int unsigned IdleRotate = 16,
    localparam int unsigned InIdxW    = $clog2(NumIn),
    localparam int unsigned OutIdxW   = $clog2(NumOut)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic [NumOut-1:0]                req_vld_i,
    input  logic [NumOut-1:0]                req_gnt_i,
    input  logic [NumOut-1:0][InIdxW-1:0]    req_idx_i,
    input  logic [NumIn-1:0]                 resp_vld_i,
    input  logic [NumIn-1:0]                 resp_rdy_i,
    input  logic [NumIn-1:0][OutIdxW-1:0]    resp_idx_i,
    output logic [NumOut-1:0][InIdxW-1:0]    req_rr_o,
    output logic [NumIn-1:0][OutIdxW-1:0]    resp_rr_o
);

    // A zero-length timer is not legal, so a disabled timer keeps one inert bit.
    localparam int unsigned TmrW = (IdleRotate == 0) ? 1 : $clog2(IdleRotate + 1);

    if (NumIn < 2) begin : g_bad_num_in
        $fatal(1, "xbar_rr_sched: NumIn must be at least 2");
    end
    if (NumOut < 2) begin : g_bad_num_out
        $fatal(1, "xbar_rr_sched: NumOut must be at least 2");
    end

    // Explicit wrap so non-power-of-two port counts and out-of-range indices land on 0.
    function automatic int unsigned succ(input int unsigned x, input int unsigned n);
        return (x >= n - 1) ? 0 : x + 1;
    endfunction

    for (genvar t = 0; t < NumOut; t++) begin : g_req
        logic [InIdxW-1:0] rr_q;
        logic [TmrW-1:0]   tmr_q;
        logic              hs;

        assign hs          = req_vld_i[t] & req_gnt_i[t];
        assign req_rr_o[t] = rr_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rr_q  <= '0;
                tmr_q <= '0;
            end else if (en_i) begin
                if (hs) begin
                    rr_q  <= InIdxW'(succ(32'(req_idx_i[t]), NumIn));
                    tmr_q <= '0;
                end else if (IdleRotate == 0) begin
                    tmr_q <= '0;
                end else if (tmr_q == TmrW'(IdleRotate - 1)) begin
                    rr_q  <= InIdxW'(succ(32'(rr_q), NumIn));
                    tmr_q <= '0;
                end else begin
                    tmr_q <= tmr_q + TmrW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NumIn; i++) begin : g_resp
        logic [OutIdxW-1:0] rr_q;
        logic [TmrW-1:0]    tmr_q;
        logic               hs;

        assign hs           = resp_vld_i[i] & resp_rdy_i[i];
        assign resp_rr_o[i] = rr_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rr_q  <= '0;
                tmr_q <= '0;
            end else if (en_i) begin
                if (hs) begin
                    rr_q  <= OutIdxW'(succ(32'(resp_idx_i[i]), NumOut));
                    tmr_q <= '0;
                end else if (IdleRotate == 0) begin
                    tmr_q <= '0;
                end else if (tmr_q == TmrW'(IdleRotate - 1)) begin
                    rr_q  <= OutIdxW'(succ(32'(rr_q), NumOut));
                    tmr_q <= '0;
                end else begin
                    tmr_q <= tmr_q + TmrW'(1);
                end
            end
        end
    end

endmodule
